// File: rtl/wf8_isa_pkg.sv
// wf8_isa_pkg: shared WF8 field widths, immediate-class test and loader state encoding
package wf8_isa_pkg;
  localparam int OPC_W  = 4;
  localparam int INSN_W = 8;
  localparam int REG_W  = 3;
  localparam int IMM_W  = 4;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  function automatic logic is_imm_class(input logic [OPC_W-1:0] opc);
    return opc[3] & opc[2] & (opc[1] | opc[0]);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-2 depth; push is allowed while full if a pop happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      if (do_push && !do_pop) count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/insn_encoder_loader.sv
// insn_encoder_loader: packs WF8 field tuples into 8-bit words and streams them through a FIFO
// into sequential instruction-memory writes starting at base_addr.
module insn_encoder_loader
  import wf8_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              fld_valid,
  output logic              fld_ready,
  input  logic [OPC_W-1:0]  fld_opcode,
  input  logic              fld_util,
  input  logic [REG_W-1:0]  fld_reg,
  input  logic [IMM_W-1:0]  fld_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INSN_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(FIFO_D) + 1;
  localparam logic [ADDR_W-1:0] ONE = 1;
  state_t state, state_nx;
  logic [ADDR_W-1:0] len_q, acc;
  logic [CW-1:0] cnt;
  logic go, push, pop, full, empty;
  function automatic logic [INSN_W-1:0] encode(input logic [OPC_W-1:0] opc, input logic util,
                                               input logic [REG_W-1:0] rb, input logic [IMM_W-1:0] imm);
    return is_imm_class(opc) ? {opc, imm} : {opc, util, rb};
  endfunction
  assign go        = start && (state == IDLE || state == DONE);
  assign busy      = state == LOAD || state == DRAIN;
  assign fld_ready = state == LOAD && !full && acc < len_q;
  assign push      = fld_valid && fld_ready;
  assign mem_we    = busy && !empty;
  assign pop       = mem_we && mem_ready;
  sync_fifo #(.WIDTH(INSN_W), .DEPTH(FIFO_D)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (encode(fld_opcode, fld_util, fld_reg, fld_imm)),
    .pop   (pop),
    .dout  (mem_wdata),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );
  // DRAIN only ends once the word leaving the FIFO is the last one
  always_comb begin
    state_nx = state;
    if (go) state_nx = (len == '0) ? DONE : LOAD;
    else if (state == LOAD && push && acc + ONE == len_q) state_nx = DRAIN;
    else if (state == DRAIN && pop && cnt == CW'(1)) state_nx = DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      acc      <= '0;
      mem_addr <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (go && len == '0) || (state == DRAIN && state_nx == DONE);
      if (go) begin
        len_q    <= len;
        acc      <= '0;
        mem_addr <= base_addr;
        err      <= 1'b0;
      end else begin
        if (push) acc <= acc + ONE;
        if (pop) begin
          mem_addr <= mem_addr + ONE;
          if (&mem_addr) err <= 1'b1;
        end
      end
    end
  end
endmodule
